// File: rtl/i2s_adc_receiver.sv
// DSP mode A serial ADC receiver: oversamples BCLK/LRCK/DATA in the clk domain,
// deserialises 16-bit L/R samples and derives a peak-hold level and beat pulse.
//
// state | meaning
// IDLE  | waiting for a BCLK rising edge with frame sync high
// DELAY | counting extra BCLK edges between frame sync and left MSB
// SHIFT | capturing 32 data bits, left MSB first
// DONE  | one clk: publish left/right samples and pulse sample_valid
module i2s_adc_receiver #(
    parameter int          CLK_SYNC_STAGES = 2,
    parameter int          DATA_DELAY      = 1,
    parameter int          DECAY_SHIFT     = 4,
    parameter logic [15:0] BEAT_THRESHOLD  = 16'd8000,
    parameter int          HOLDOFF_FRAMES  = 2400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        BCLK,
    input  logic        ADC_LR_CLK,
    input  logic        ADC_DATA,
    output logic [15:0] left_sample,
    output logic [15:0] right_sample,
    output logic        sample_valid,
    output logic [15:0] level,
    output logic        beat,
    output logic        sync_err
);

    localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
    localparam int DW = (DATA_DELAY > 1) ? $clog2(DATA_DELAY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    logic [CLK_SYNC_STAGES-1:0] bclk_sync, lr_sync, data_sync;
    logic                       bclk_prev;
    logic                       sync_bclk, sync_lr, sync_data, bre;

    state_t        state, state_nxt;
    logic [4:0]    bcnt, bcnt_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [31:0]   sr, sr_nxt;
    logic          restart, err_set;

    logic [HW-1:0] holdoff, hold_dec;
    logic [15:0]   abs_l, abs_r, peak, level_dec;
    logic          fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync <= '0;
            lr_sync   <= '0;
            data_sync <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[CLK_SYNC_STAGES-2:0], BCLK};
            lr_sync   <= {lr_sync[CLK_SYNC_STAGES-2:0], ADC_LR_CLK};
            data_sync <= {data_sync[CLK_SYNC_STAGES-2:0], ADC_DATA};
            bclk_prev <= sync_bclk;
        end
    end

    assign sync_bclk = bclk_sync[CLK_SYNC_STAGES-1];
    assign sync_lr   = lr_sync[CLK_SYNC_STAGES-1];
    assign sync_data = data_sync[CLK_SYNC_STAGES-1];
    assign bre       = sync_bclk & ~bclk_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bcnt  <= '0;
            dcnt  <= '0;
            sr    <= '0;
        end else begin
            state <= state_nxt;
            bcnt  <= bcnt_nxt;
            dcnt  <= dcnt_nxt;
            sr    <= sr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        bcnt_nxt  = bcnt;
        dcnt_nxt  = dcnt;
        sr_nxt    = sr;
        restart   = 1'b0;
        err_set   = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            bcnt_nxt  = '0;
            sr_nxt    = '0;
        end else begin
            case (state)
                IDLE: restart = bre & sync_lr;
                DELAY: begin
                    if (bre) begin
                        if (sync_lr) begin
                            err_set = 1'b1;
                            restart = 1'b1;
                        end else if (dcnt <= DW'(1)) begin
                            state_nxt = SHIFT;
                            bcnt_nxt  = '0;
                        end else begin
                            dcnt_nxt = dcnt - DW'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (bre) begin
                        if (sync_lr) begin
                            err_set = 1'b1;
                            restart = 1'b1;
                        end else begin
                            sr_nxt   = {sr[30:0], sync_data};
                            bcnt_nxt = bcnt + 5'd1;
                            if (bcnt == 5'd31) state_nxt = DONE;
                        end
                    end
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
            // A frame sync always starts a fresh frame, even when it aborts one.
            if (restart) begin
                bcnt_nxt = '0;
                sr_nxt   = '0;
                if (DATA_DELAY <= 1) begin
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = DELAY;
                    dcnt_nxt  = DW'(DATA_DELAY - 1);
                end
            end
        end
    end

    function automatic logic [15:0] mag16(input logic [15:0] x);
        if (!x[15])            return x;
        else if (x == 16'h8000) return 16'h7FFF;
        else                    return ~x + 16'd1;
    endfunction

    assign abs_l     = mag16(left_sample);
    assign abs_r     = mag16(right_sample);
    assign peak      = (abs_l > abs_r) ? abs_l : abs_r;
    assign level_dec = level - (level >> DECAY_SHIFT);
    // Holdoff is decremented before the zero test so beats land HOLDOFF_FRAMES apart.
    assign hold_dec  = (holdoff != '0) ? holdoff - HW'(1) : '0;
    assign fire      = (peak >= BEAT_THRESHOLD) && (hold_dec == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            level        <= '0;
            beat         <= 1'b0;
            sync_err     <= 1'b0;
            holdoff      <= '0;
        end else begin
            sample_valid <= 1'b0;
            beat         <= 1'b0;
            if (err_set) sync_err <= 1'b1;
            if (state == DONE && enable) begin
                left_sample  <= sr[31:16];
                right_sample <= sr[15:0];
                sample_valid <= 1'b1;
            end
            if (sample_valid) begin
                level   <= (peak > level) ? peak : level_dec;
                beat    <= fire;
                holdoff <= fire ? HW'(HOLDOFF_FRAMES) : hold_dec;
            end
        end
    end

endmodule
